// File: rtl/lvda_timing_pkg.sv
// Shared types and defaults for the LVDA timing sequencer.
//   seq_state_t : sequencer mode (halted, free-running, single bit time)
//   ct_t        : clock time within a bit time (W, X, Y, Z)
package lvda_timing_pkg;

    localparam int unsigned BT_MAX_DEFAULT = 14;
    localparam int unsigned PH_MAX_DEFAULT = 3;
    localparam int unsigned BT_W           = 4;
    localparam int unsigned PH_W           = 2;
    localparam int unsigned DRV_W          = 4;

    typedef enum logic [1:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP
    } seq_state_t;

    typedef enum logic [1:0] {
        CT_W,
        CT_X,
        CT_Y,
        CT_Z
    } ct_t;

    // One-hot drive vector {Z, Y, X, W} for a clock time.
    function automatic logic [DRV_W-1:0] ct_onehot(input ct_t ct);
        return DRV_W'(1) << ct;
    endfunction

endpackage

// File: rtl/lvda_bt_ph_counter.sv
// Bit-time / phase counter pair.
//   clk, rst_n : clock, async active-low reset (both counters reset to 1)
//   en         : Z-boundary strobe; advances BT, and PH when BT wraps
//   bt, ph     : current bit time 1..BT_MAX, phase 1..PH_MAX
module lvda_bt_ph_counter
    import lvda_timing_pkg::*;
#(
    parameter int unsigned BT_MAX = BT_MAX_DEFAULT,
    parameter int unsigned PH_MAX = PH_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [BT_W-1:0] bt,
    output logic [PH_W-1:0] ph
);

    // Both counters are 1-based and wrap back to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bt <= BT_W'(1);
            ph <= PH_W'(1);
        end else if (en) begin
            if (bt == BT_W'(BT_MAX)) begin
                bt <= BT_W'(1);
                if (ph == PH_W'(PH_MAX)) begin
                    ph <= PH_W'(1);
                end else begin
                    ph <= ph + PH_W'(1);
                end
            end else begin
                bt <= bt + BT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lvda_timing_seq.sv
// LVDA timing sequencer: rotates the W/X/Y/Z clock-time drives while running
// or stepping, and tracks bit time / phase.
//   SIM_CLK, SIM_RST   : clock, async active-low reset
//   RUN                : level, continuous sequencing while high
//   STEP               : pulse, one bit time while halted
//   WDA/XDA/YDA/ZDA    : registered one-hot clock-time drives
//   BT, PH             : current bit time and phase (1-based)
//   BT_END, PH_END     : registered end-of-bit-time / end-of-phase markers
//   HALTED             : registered, high while halted
module lvda_timing_seq
    import lvda_timing_pkg::*;
#(
    parameter int unsigned BT_MAX = BT_MAX_DEFAULT,
    parameter int unsigned PH_MAX = PH_MAX_DEFAULT
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            RUN,
    input  logic            STEP,
    output logic            WDA,
    output logic            XDA,
    output logic            YDA,
    output logic            ZDA,
    output logic [BT_W-1:0] BT,
    output logic [PH_W-1:0] PH,
    output logic            BT_END,
    output logic            PH_END,
    output logic            HALTED
);

    seq_state_t       state_q, state_d;
    ct_t              ct_q, ct_d;
    logic [DRV_W-1:0] drv_q, drv_d;
    logic             bt_end_q, bt_end_d;
    logic             ph_end_q, ph_end_d;
    logic             halted_q, halted_d;
    logic             z_end;

    // Mode and clock-time registers plus registered outputs.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q  <= ST_HALT;
            ct_q     <= CT_W;
            drv_q    <= '0;
            bt_end_q <= 1'b0;
            ph_end_q <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ct_q     <= ct_d;
            drv_q    <= drv_d;
            bt_end_q <= bt_end_d;
            ph_end_q <= ph_end_d;
            halted_q <= halted_d;
        end
    end

    // Next mode / clock time; mode changes only at the Z boundary once active.
    always_comb begin
        state_d  = state_q;
        ct_d     = ct_q;
        z_end    = 1'b0;
        drv_d    = '0;
        bt_end_d = 1'b0;
        ph_end_d = 1'b0;
        halted_d = 1'b1;

        unique case (state_q)
            ST_HALT: begin
                // RUN has priority; a simultaneous STEP is dropped.
                if (RUN) begin
                    state_d = ST_RUN;
                    ct_d    = CT_W;
                end else if (STEP) begin
                    state_d = ST_STEP;
                    ct_d    = CT_W;
                end
            end
            ST_RUN, ST_STEP: begin
                if (ct_q != CT_Z) begin
                    ct_d = ct_t'(ct_q + 2'd1);
                end else begin
                    z_end = 1'b1;
                    ct_d  = CT_W;
                    // RUN at the boundary continues (or converts a step) gaplessly.
                    state_d = RUN ? ST_RUN : ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
                ct_d    = CT_W;
            end
        endcase

        // BT cannot change on an edge entering Z, so current BT marks PH_END.
        if (state_d != ST_HALT) begin
            drv_d    = ct_onehot(ct_d);
            bt_end_d = (ct_d == CT_Z);
            ph_end_d = (ct_d == CT_Z) && (BT == BT_W'(BT_MAX));
            halted_d = 1'b0;
        end
    end

    lvda_bt_ph_counter #(
        .BT_MAX (BT_MAX),
        .PH_MAX (PH_MAX)
    ) u_bt_ph_counter (
        .clk   (SIM_CLK),
        .rst_n (SIM_RST),
        .en    (z_end),
        .bt    (BT),
        .ph    (PH)
    );

    assign {ZDA, YDA, XDA, WDA} = drv_q;
    assign BT_END = bt_end_q;
    assign PH_END = ph_end_q;
    assign HALTED = halted_q;

endmodule
